radix4_fft4: RTL and testbench

- Pipelined 4-point DFT (single radix-4 butterfly) on four real, unsigned input samples.
- Produces four complex bins X[k] = sum x[n]·(-j)^(nk), n,k = 0..3, as real and imaginary parts.
- Sits as a leaf compute block in the DSP datapath.
- Input is a valid-qualified, one-sample-set-per-cycle stream with no backpressure.

---
 rtl/radix4_fft_pkg.sv | 25 ++
 rtl/radix4_bfly2.sv | 16 +
 rtl/radix4_fft4.sv | 93 +++++++++
 tb/tb_radix4_fft4.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/radix4_fft_pkg.sv
// rtl/radix4_fft_pkg.sv - shared widths, internal word type and output reduction for radix4_fft4
// Output reduction wraps by default; RADIX4_FFT_SCALE_EN selects divide-by-4 before wrapping.
package radix4_fft_pkg;

  localparam int W_DEF  = 4;
  localparam int OW_DEF = 4;

  // Three guard bits: a 4-term sum of unsigned W-bit samples plus sign.
  function automatic int calc_iw(input int w);
    return w + 3;
  endfunction

  localparam int IW_DEF = calc_iw(W_DEF);

  typedef logic signed [IW_DEF-1:0] iword_t;

  function automatic logic signed [31:0] reduce_word(input logic signed [31:0] v);
`ifdef RADIX4_FFT_SCALE_EN
    return v >>> 2;
`else
    return v;
`endif
  endfunction

endpackage

// File: rtl/radix4_bfly2.sv
// rtl/radix4_bfly2.sv - 2-input signed sum/difference unit
module radix4_bfly2
  import radix4_fft_pkg::*;
#(
  parameter int IW = IW_DEF
) (
  input  logic signed [IW-1:0] p,
  input  logic signed [IW-1:0] q,
  output logic signed [IW-1:0] sum,
  output logic signed [IW-1:0] diff
);

  assign sum  = p + q;
  assign diff = p - q;

endmodule

// File: rtl/radix4_fft4.sv
// rtl/radix4_fft4.sv - 2-stage pipelined 4-point DFT of real unsigned samples
// Optional build macro RADIX4_FFT_SCALE_EN scales results by 1/4 before wrapping.
module radix4_fft4
  import radix4_fft_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int OW = OW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [W-1:0]  x_0,
  input  logic [W-1:0]  x_1,
  input  logic [W-1:0]  x_2,
  input  logic [W-1:0]  x_3,
  output logic          out_valid,
  output logic [OW-1:0] X_real_0,
  output logic [OW-1:0] X_real_1,
  output logic [OW-1:0] X_real_2,
  output logic [OW-1:0] X_real_3,
  output logic [OW-1:0] X_imag_0,
  output logic [OW-1:0] X_imag_1,
  output logic [OW-1:0] X_imag_2,
  output logic [OW-1:0] X_imag_3
);

  localparam int IW = calc_iw(W);

  function automatic logic [OW-1:0] to_out(input logic signed [IW-1:0] v);
    return OW'(reduce_word(32'(v)));
  endfunction

  logic signed [IW-1:0] xe_0, xe_1, xe_2, xe_3;
  logic signed [IW-1:0] a_d, b_d, c_d, d_d;
  logic signed [IW-1:0] a_q, b_q, c_q, d_q;
  logic signed [IW-1:0] s_ac, d_ac;
  logic                 v1;

  assign xe_0 = {{(IW-W){1'b0}}, x_0};
  assign xe_1 = {{(IW-W){1'b0}}, x_1};
  assign xe_2 = {{(IW-W){1'b0}}, x_2};
  assign xe_3 = {{(IW-W){1'b0}}, x_3};

  radix4_bfly2 #(.IW(IW)) u_bfly_02 (.p(xe_0), .q(xe_2), .sum(a_d), .diff(b_d));
  radix4_bfly2 #(.IW(IW)) u_bfly_13 (.p(xe_1), .q(xe_3), .sum(c_d), .diff(d_d));
  radix4_bfly2 #(.IW(IW)) u_bfly_ac (.p(a_q),  .q(c_q),  .sum(s_ac), .diff(d_ac));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        a_q <= a_d;
        b_q <= b_d;
        c_q <= c_d;
        d_q <= d_d;
      end
    end
  end

  // Outputs hold the last valid result while the pipe is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      X_real_0  <= '0;
      X_real_1  <= '0;
      X_real_2  <= '0;
      X_real_3  <= '0;
      X_imag_1  <= '0;
      X_imag_3  <= '0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        X_real_0 <= to_out(s_ac);
        X_real_1 <= to_out(b_q);
        X_imag_1 <= to_out(-d_q);
        X_real_2 <= to_out(d_ac);
        X_real_3 <= to_out(b_q);
        X_imag_3 <= to_out(d_q);
      end
    end
  end

  // Real input: bins 0 and 2 have no imaginary part.
  assign X_imag_0 = '0;
  assign X_imag_2 = '0;

endmodule

// File: tb/tb_radix4_fft4.sv
// tb/tb_radix4_fft4.sv - self-checking bench for radix4_fft4 (directed vectors plus streamed grid)
module tb_radix4_fft4;

  localparam int W  = 4;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  x_0, x_1, x_2, x_3;
  logic          out_valid;
  logic [OW-1:0] X_real_0, X_real_1, X_real_2, X_real_3;
  logic [OW-1:0] X_imag_0, X_imag_1, X_imag_2, X_imag_3;

  int n_checks = 0;
  int n_pass   = 0;

  logic        prev_v;
  logic [15:0] prev_s;
  logic [31:0] last_exp;

  always #5 clk = ~clk;

  radix4_fft4 #(.W(W), .OW(OW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .x_0(x_0), .x_1(x_1), .x_2(x_2), .x_3(x_3),
    .out_valid(out_valid),
    .X_real_0(X_real_0), .X_real_1(X_real_1), .X_real_2(X_real_2), .X_real_3(X_real_3),
    .X_imag_0(X_imag_0), .X_imag_1(X_imag_1), .X_imag_2(X_imag_2), .X_imag_3(X_imag_3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Direct DFT: (-j)^m over m = n*k mod 4, then reduction, packed {Re0,Im0,...,Re3,Im3}.
  function automatic logic [31:0] model(input logic [15:0] s);
    logic [31:0] r;
    int xs[4];
    int re, im;
    r = '0;
    for (int n = 0; n < 4; n++) xs[n] = int'(s[15-4*n -: 4]);
    for (int k = 0; k < 4; k++) begin
      re = 0;
      im = 0;
      for (int n = 0; n < 4; n++) begin
        case ((n * k) % 4)
          0: re += xs[n];
          1: im -= xs[n];
          2: re -= xs[n];
          default: im += xs[n];
        endcase
      end
`ifdef RADIX4_FFT_SCALE_EN
      re = re >>> 2;
      im = im >>> 2;
`endif
      r[31-8*k -: 4] = 4'(re);
      r[27-8*k -: 4] = 4'(im);
    end
    return r;
  endfunction

  function automatic logic [63:0] dut_word();
    return {31'b0, out_valid, X_real_0, X_imag_0, X_real_1, X_imag_1,
            X_real_2, X_imag_2, X_real_3, X_imag_3};
  endfunction

  task automatic drive(input logic v, input logic [15:0] s);
    in_valid = v;
    x_0 = s[15:12];
    x_1 = s[11:8];
    x_2 = s[7:4];
    x_3 = s[3:0];
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One set after idle: out_valid must stay low one cycle, then show the result.
  task automatic directed(input string tag, input logic [15:0] s, input logic [31:0] exp);
    drive(1'b1, s);
    cycle();
    check({tag, "_lat1"}, {63'b0, out_valid}, 64'd0);
    drive(1'b0, 16'h0000);
    cycle();
    check(tag, dut_word(), {31'b0, 1'b1, exp});
  endtask

  task automatic stream_cycle(input logic v, input logic [15:0] s);
    drive(v, s);
    cycle();
    if (prev_v) last_exp = model(prev_s);
    check("stream", dut_word(), {31'b0, prev_v, last_exp});
    prev_v = v;
    prev_s = s;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'($urandom));
      cycle();
      check("reset_hold", dut_word(), 64'd0);
    end
    rst_n = 1'b1;
    drive(1'b0, 16'h0000);
    cycle();
    check("post_reset_idle", dut_word(), 64'd0);

`ifdef RADIX4_FFT_SCALE_EN
    directed("impulse", 16'h1000, 32'h0000_0000);
    directed("dc1",     16'h1111, 32'h1000_0000);
    directed("dc15",    16'hFFFF, 32'hF000_0000);
    directed("ramp",    16'h1234, 32'h20F0_F0FF);
`else
    directed("impulse", 16'h1000, 32'h1010_1010);
    directed("dc1",     16'h1111, 32'h4000_0000);
    directed("dc15",    16'hFFFF, 32'hC000_0000);
    directed("ramp",    16'h1234, 32'hA0E2_E0EE);
`endif

    // Asynchronous reset in the middle of a stream, away from any clock edge.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h1234);
      cycle();
    end
    rst_n = 1'b0;
    #1;
    check("async_reset", dut_word(), 64'd0);
    cycle();
    rst_n = 1'b1;
    drive(1'b0, 16'h0000);
    cycle();
    check("async_reset_idle", dut_word(), 64'd0);
    directed("first_after_reset", 16'h1000, model(16'h1000));

    prev_v   = 1'b0;
    prev_s   = 16'h0000;
    last_exp = model(16'h1000);

    for (int a = 1; a < 16; a++)
      for (int b = 1; b < 16; b++)
        for (int c = 1; c < 16; c++)
          for (int d = 1; d < 16; d++)
            stream_cycle(1'b1, {4'(a), 4'(b), 4'(c), 4'(d)});

    for (int i = 0; i < 300; i++)
      stream_cycle((i % 5 != 3) && ($urandom_range(0, 7) != 0), 16'($urandom));
    stream_cycle(1'b0, 16'h0000);
    stream_cycle(1'b0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
